mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Decodes the registered 2-bit memory read/write controls, address (ALU result) and store data, and drives a req/ack data-memory bus.
- Holds the pipeline with a stall while the access is outstanding.
- Returns aligned, sign- or zero-extended load data to the MEM/WB path.

Parameters:
- WAIT_MAX, 16, cycle limit for an outstanding request; used only when MEM_TIMEOUT_EN is defined.

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- Mem_alu_result  in  32  byte address
- Mem_busB  in  32  store data
- Mem_MemWr  in  2  00 none, 01 sw, 10 sb, 11 sh
- Mem_MemRead  in  2  00 none, 01 lw, 10 lb (signed), 11 lbu
- dm_req  out  1  bus request, registered
- dm_we  out  1  1 = write
- dm_addr  out  30  word address [31:2]
- dm_be  out  4  byte enables
- dm_wdata  out  32  lane-replicated store data
- dm_rdata  in  32  read data, valid with dm_ack
- dm_ack  in  1  one-cycle completion pulse
- Mem_stall  out  1  freeze PC/IF/ID/EX/MEM registers
- Mem_load_data  out  32  extended load result
- Mem_misalign  out  1  one-cycle alignment-fault pulse
- Mem_timeout  out  1  sticky fault; exists only with MEM_TIMEOUT_EN

Behaviour:
- Reset (async, Rst_n=0):
  - state=IDLE.
  - dm_req, dm_we, dm_addr, dm_be, dm_wdata, Mem_load_data, Mem_misalign, Mem_timeout all 0.
  - dm_req falls immediately, even mid-request.
- Op present when Mem_MemRead!=00 or Mem_MemWr!=00.
  - Both nonzero is illegal: write wins, read ignored.
- States: IDLE, REQ, DONE.
- IDLE:
  - Op present and aligned: capture dm_we/addr/be/wdata, set dm_req=1, go to REQ.
  - Mem_stall=1 combinationally in this cycle.
- REQ:
  - dm_req and all bus outputs held stable until dm_ack=1.
  - dm_ack is sampled only in REQ and may arrive in the first REQ cycle.
  - On ack: dm_req=0; for reads, Mem_load_data is registered from extended dm_rdata; go to DONE.
  - Mem_stall=1.
- DONE:
  - Mem_stall=0 for exactly one cycle, so the pipeline advances and Mem_load_data is consumed.
  - Then go to IDLE.
  - Minimum access latency is 3 cycles (IDLE, REQ, DONE); each extra ack wait adds 1.
  - Back-to-back ops restart from IDLE.
- Alignment:
  - lw/sw require addr[1:0]=00; sh requires addr[0]=0; bytes are always aligned.
  - Misaligned op in IDLE: no bus request, Mem_stall=0, Mem_misalign=1 for one cycle, Mem_load_data=0.
- Byte enables:
  - sw: 1111.
  - sh: 0011 at addr[1]=0, 1100 at addr[1]=1.
  - sb: one-hot 1<<addr[1:0].
- Write data:
  - Byte replicated to all 4 lanes; halfword replicated to both halves.
- Read extension:
  - Byte selected by addr[1:0].
  - lb sign-extends bit 7; lbu zero-extends.
  - lw passes through unchanged.
- Spurious dm_ack in IDLE or DONE is ignored.
- No op: state stays IDLE, Mem_stall=0.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8-bit wait counter runs in REQ and clears on entry to REQ.
  - When the count reaches WAIT_MAX with no ack: dm_req=0, Mem_timeout=1 (sticky until reset), Mem_load_data=0, go to DONE.
  - A late ack after that is ignored.
- Undefined:
  - No counter and no Mem_timeout port; REQ waits indefinitely.

Decomposition:
- Shared package mem_pkg:
  - MemRead encodings: MR_NONE, MR_LW, MR_LB, MR_LBU.
  - MemWr encodings: MW_NONE, MW_SW, MW_SB, MW_SH.
  - State enum: ST_IDLE, ST_REQ, ST_DONE.
- One sub-module, mem_load_align: combinational byte select plus sign/zero extension, taking rdata, addr[1:0] and the read type. It is reused by the MEM/WB forwarding path.

Test Plan:
1. lw at addr 0x0000_0010, ack 2 cycles after req, rdata 0xDEADBEEF:
   - dm_addr=0x4, dm_be=1111.
   - Mem_stall high 3 cycles, then low.
   - Mem_load_data=0xDEADBEEF.
2. lb at addr 0x13, rdata 0x80FF_7F01 (byte at addr[1:0]=11 is 0x80):
   - Mem_load_data=0xFFFF_FF80.
   - The same access as lbu returns 0x0000_0080.
3. sh at addr 0x22, busB 0x1234_ABCD, ack 1 cycle after req:
   - dm_we=1, dm_be=1100, dm_wdata=0xABCD_ABCD.
4. sw at addr 0x21:
   - Mem_misalign pulses once.
   - dm_req stays 0 and Mem_stall stays 0.
5. Reset mid-REQ:
   - Rst_n low with dm_req=1 drops dm_req asynchronously.
   - After release, state is IDLE and no ack is consumed.
6. MEM_TIMEOUT_EN with WAIT_MAX=16, ack never asserted:
   - Mem_timeout sets after 16 REQ cycles.
   - Mem_stall releases for one cycle.
   - A later ack is ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the MEM-stage data-memory access controller
// and the load alignment unit.
package mem_pkg;

  typedef enum logic [1:0] {
    MR_NONE = 2'b00,
    MR_LW   = 2'b01,
    MR_LB   = 2'b10,
    MR_LBU  = 2'b11
  } mem_read_e;

  typedef enum logic [1:0] {
    MW_NONE = 2'b00,
    MW_SW   = 2'b01,
    MW_SB   = 2'b10,
    MW_SH   = 2'b11
  } mem_wr_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // A write takes priority when both controls are (illegally) set.
  function automatic logic op_aligned(mem_wr_e wr, mem_read_e rd, logic [1:0] lo);
    logic ok;
    ok = 1'b1;
    if (wr != MW_NONE) begin
      if (wr == MW_SW) ok = (lo == 2'b00);
      else if (wr == MW_SH) ok = ~lo[0];
    end else if (rd == MR_LW) begin
      ok = (lo == 2'b00);
    end
    return ok;
  endfunction

  function automatic logic [3:0] access_be(logic isWrite, mem_wr_e wr, mem_read_e rd,
                                           logic [1:0] lo);
    logic [3:0] be;
    be = 4'b0001 << lo;
    if (isWrite) begin
      if (wr == MW_SW) be = 4'b1111;
      else if (wr == MW_SH) be = lo[1] ? 4'b1100 : 4'b0011;
    end else if (rd == MR_LW) begin
      be = 4'b1111;
    end
    return be;
  endfunction

  function automatic logic [31:0] store_data(mem_wr_e wr, logic [31:0] d);
    logic [31:0] w;
    case (wr)
      MW_SB:   w = {4{d[7:0]}};
      MW_SH:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational byte select and sign/zero extension of returned load data;
// also used by the MEM/WB forwarding path.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  mem_read_e   rd_type_i,
  output logic [31:0] data_o
);

  logic [7:0] byteSel;

  always_comb begin
    byteSel = rdata_i[{addr_i, 3'b000} +: 8];
    case (rd_type_i)
      MR_LW:   data_o = rdata_i;
      MR_LB:   data_o = {{24{byteSel[7]}}, byteSel};
      MR_LBU:  data_o = {24'h000000, byteSel};
      default: data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage req/ack data-memory access controller with pipeline stall.
// Optional request timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl
  import mem_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
  parameter int unsigned WAIT_MAX = 16
)
`endif
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] Mem_alu_result,
  input  logic [31:0] Mem_busB,
  input  logic [1:0]  Mem_MemWr,
  input  logic [1:0]  Mem_MemRead,
  output logic        dm_req,
  output logic        dm_we,
  output logic [29:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        Mem_stall,
  output logic [31:0] Mem_load_data,
  output logic        Mem_misalign
`ifdef MEM_TIMEOUT_EN
  ,
  output logic        Mem_timeout
`endif
);

  state_e      state_q, state_d;
  logic        req_q, req_d, we_q, we_d, misalign_q, misalign_d;
  logic [29:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d, load_q, load_d, extData;
  mem_read_e   rdType_q, rdType_d;
  logic [1:0]  addrLo_q, addrLo_d;
  mem_read_e   rdOp;
  mem_wr_e     wrOp;
  logic        isWrite, opValid, stall;
`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] WaitLast = 8'(WAIT_MAX - 1);
  logic [7:0]  cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
`endif

  assign rdOp    = mem_read_e'(Mem_MemRead);
  assign wrOp    = mem_wr_e'(Mem_MemWr);
  assign isWrite = (wrOp != MW_NONE);
  assign opValid = isWrite || (rdOp != MR_NONE);

  mem_load_align u_align (
    .rdata_i  (dm_rdata),
    .addr_i   (addrLo_q),
    .rd_type_i(rdType_q),
    .data_o   (extData)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rdType_d   = rdType_q;
    addrLo_d   = addrLo_q;
    load_d     = load_q;
    misalign_d = 1'b0;
    stall      = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (opValid) begin
          if (op_aligned(wrOp, rdOp, Mem_alu_result[1:0])) begin
            stall    = 1'b1;
            req_d    = 1'b1;
            we_d     = isWrite;
            addr_d   = Mem_alu_result[31:2];
            be_d     = access_be(isWrite, wrOp, rdOp, Mem_alu_result[1:0]);
            wdata_d  = isWrite ? store_data(wrOp, Mem_busB) : 32'h0000_0000;
            rdType_d = isWrite ? MR_NONE : rdOp;
            addrLo_d = Mem_alu_result[1:0];
`ifdef MEM_TIMEOUT_EN
            cnt_d    = 8'h00;
`endif
            state_d  = ST_REQ;
          end else begin
            misalign_d = 1'b1;
            load_d     = 32'h0000_0000;
          end
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        if (dm_ack) begin
          req_d   = 1'b0;
          if (rdType_q != MR_NONE) load_d = extData;
          state_d = ST_DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == WaitLast) begin
          req_d     = 1'b0;
          timeout_d = 1'b1;
          load_d    = 32'h0000_0000;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'h01;
        end
`endif
      end
      // One stall-free cycle lets the pipeline consume the result.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdType_q   <= MR_NONE;
      addrLo_q   <= '0;
      load_q     <= '0;
      misalign_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rdType_q   <= rdType_d;
      addrLo_q   <= addrLo_d;
      load_q     <= load_d;
      misalign_q <= misalign_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign dm_req        = req_q;
  assign dm_we         = we_q;
  assign dm_addr       = addr_q;
  assign dm_be         = be_q;
  assign dm_wdata      = wdata_q;
  assign Mem_stall     = stall;
  assign Mem_load_data = load_q;
  assign Mem_misalign  = misalign_q;
`ifdef MEM_TIMEOUT_EN
  assign Mem_timeout   = timeout_q;
`endif

endmodule
